fetch_controller: RTL
=====================

# fetch_controller

Sequences instruction fetch around the program-counter register. It drives the PC's next-address and freeze inputs, runs the request/ready handshake with instruction memory, and buffers the fetched word when the decode stage stalls. It applies branch redirects, including redirects that arrive while a memory access is still outstanding, and it loads the IF/ID stage. It sits between the PC register, instruction memory, the hazard unit and EX-stage branch resolution.

## Interface
- INC, 4: PC increment per sequential fetch.
- TIMEOUT, 16: consecutive non-ready request cycles before fetch error; 0 disables the timeout.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately. The PC register's reset is driven from ~reset at top level.
- pc  in  32  current PC register value.
- pc_next  out  32  to PC next-address input; combinational.
- pc_freeze  out  1  to PC freeze input; combinational.
- imem_req  out  1  instruction fetch request; decoded from state.
- imem_addr  out  32  fetch address; always equal to pc.
- imem_rdata  in  32  fetched word; valid when imem_ready=1.
- imem_ready  in  1  access complete; meaningful only while imem_req=1.
- stall  in  1  hazard unit: IF/ID must hold its contents.
- branch_taken  in  1  single-cycle redirect pulse from EX.
- branch_target  in  32  redirect address; sampled when branch_taken=1.
- if_valid  out  1  IF/ID entry holds a valid instruction; registered.
- if_pc  out  32  PC of the IF/ID instruction; registered.
- if_instr  out  32  IF/ID instruction word; registered.
- fetch_error  out  1  sticky timeout flag; registered.

## Operation
- **States**
  - S_START: entered on reset.
  - S_FETCH
  - S_HOLD: a word is buffered in the skid register.
  - S_ERR
- **Internal registers**
  - skid_instr/skid_pc: buffered word and its PC.
  - redir_pend/redir_target: pending redirect.
  - wait_cnt: timeout counter.
- **Combinational rules**
  - Whenever pc_freeze=1, pc_next=pc.
  - When advancing, pc_next = redir target if a redirect applies, else (pc+INC) mod 2^32.
  - imem_req=1 only in S_FETCH.
- **S_START** (pc_freeze=1, no request)
  - Next cycle → S_FETCH.
  - If branch_taken=1: pc_freeze=0, pc_next=branch_target, then → S_FETCH.
- **S_FETCH, imem_ready=0**
  - pc_freeze=1; wait_cnt++.
  - If branch_taken=1: redir_pend<=1, redir_target<=branch_target. The latest pulse overwrites earlier ones.
- **S_FETCH, imem_ready=1**
  - pc_freeze=0; wait_cnt<=0.
  - If branch_taken=1 or redir_pend=1:
    - word is discarded; pc_next = branch_target (this cycle's pulse has priority over redir_target).
    - redir_pend<=0.
  - Else if stall=0: if_valid<=1, if_pc<=pc, if_instr<=imem_rdata.
  - Else (stall=1): skid<=word, → S_HOLD.
- **S_HOLD** (pc is already advanced; no request)
  - pc_freeze=1.
  - When stall=0: IF/ID loads from skid with if_valid=1, → S_FETCH.
  - If branch_taken=1: skid is discarded, pc_freeze=0, pc_next=branch_target, → S_FETCH. This applies regardless of stall.
- **Flush**
  - branch_taken=1 forces if_valid<=0 at the next edge. Flush overrides stall and any IF/ID load in the same cycle.
- **IF/ID hold**
  - Outside flush and loads, IF/ID holds its contents while stall=1.
  - With stall=0 and no load, if_valid<=0 (bubble).
- **Timeout**
  - Condition: TIMEOUT≠0, state S_FETCH, wait_cnt==TIMEOUT-1, and imem_ready=0.
  - Effect: fetch_error<=1, if_valid<=0, → S_ERR.
  - S_ERR: pc_freeze=1, no request, branch_taken ignored; exit only via reset.
- **Reset values**
  - Registered outputs: if_valid=0, if_pc=0, if_instr=0, fetch_error=0.
  - Internal: state=S_START, redir_pend=0, wait_cnt=0.
  - Combinational outputs in S_START: imem_req=0, pc_freeze=1, pc_next=pc.

## Timing
- Zero-wait memory (ready in the request cycle): one instruction per cycle; IF/ID is loaded at the edge ending the request cycle.
- An access with N wait cycles occupies N+1 request cycles.
- Redirect latency:
  - pulse coinciding with ready or in S_HOLD: PC equals target after 1 edge;
  - otherwise: PC equals target at the edge ending the outstanding access.
- Reset asserted mid-access: imem_req drops asynchronously; an in-flight imem_ready has no effect.
- PC wrap: pc=0xFFFFFFFC, INC=4 → pc_next=0x00000000.

## Test plan
- **Sequential fetch.** Release reset; memory returns pc+0x100 with zero wait. Required: if_pc = 0, 4, 8 on consecutive cycles with if_valid=1, and if_instr=0x100, 0x104, 0x108.
- **Stall with ready.** Assert stall for 3 cycles coinciding with ready at pc=8. Required: skid holds word 8; pc=0xC frozen; no request during the hold; after release, if_pc=8, if_valid=1, then fetch resumes at 0xC.
- **Redirect during wait.** Ready delayed 3 cycles at pc=0x10; branch_taken with target 0x40 in wait cycle 1. Required: fetched word discarded, if_valid=0, next imem_addr=0x40.
- **Simultaneous events.** branch_taken (target 0x80) with ready and stall all at 1. Required: no IF/ID load, if_valid=0, pc=0x80 after 1 edge, state S_FETCH.
- **Timeout.** TIMEOUT=4, ready held at 0. Required: fetch_error=1 after exactly 4 request cycles; imem_req=0, pc frozen, branch ignored; reset clears fetch_error to 0.
- **Async reset and wrap.** Reset asserted mid-access: imem_req=0 before the next edge; all outputs at their reset values. Separately, pc=0xFFFFFFFC with ready: pc_next=0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch around the PC register.
// Drives PC next-address/freeze, runs the imem request/ready handshake,
// buffers a fetched word in a skid register while decode stalls, applies
// branch redirects (also those arriving mid-access) and loads IF/ID.
module fetch_controller #(
  parameter int unsigned INC     = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_freeze,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_error
);

  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD, S_ERR} state_t;

  state_t      state, state_nx;
  logic [31:0] skid_instr, skid_pc;
  logic        redir_pend;
  logic [31:0] redir_target;
  logic [31:0] wait_cnt;

  logic fetch_done, redirect_now, load_fetch, to_skid, load_skid;
  logic timeout_hit, flush;

  assign imem_addr = pc;

  // Event decode shared by the FSM and the datapath registers
  always_comb begin
    fetch_done   = (state == S_FETCH) && imem_ready;
    redirect_now = fetch_done && (branch_taken || redir_pend);
    load_fetch   = fetch_done && !redirect_now && !stall;
    to_skid      = fetch_done && !redirect_now && stall;
    load_skid    = (state == S_HOLD) && !stall && !branch_taken;
    timeout_hit  = (TIMEOUT != 0) && (state == S_FETCH) && !imem_ready &&
                   (wait_cnt == 32'(TIMEOUT - 1));
    flush        = branch_taken && (state != S_ERR);
  end

  // Next-state and PC control outputs
  always_comb begin
    state_nx  = state;
    pc_freeze = 1'b1;
    pc_next   = pc;
    imem_req  = 1'b0;
    case (state)
      S_START: begin
        state_nx = S_FETCH;
        if (branch_taken) begin
          pc_freeze = 1'b0;
          pc_next   = branch_target;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_freeze = 1'b0;
          if (branch_taken)    pc_next = branch_target;
          else if (redir_pend) pc_next = redir_target;
          else                 pc_next = pc + 32'(INC);
          if (to_skid) state_nx = S_HOLD;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_freeze = 1'b0;
          pc_next   = branch_target;
          state_nx  = S_FETCH;
        end else if (!stall) begin
          state_nx = S_FETCH;
        end
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_START;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_START;
    else        state <= state_nx;
  end

  // Pending redirect, wait counter and skid buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_pend   <= 1'b0;
      redir_target <= '0;
      wait_cnt     <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
    end else if (state == S_FETCH) begin
      if (imem_ready) begin
        redir_pend <= 1'b0;
        wait_cnt   <= '0;
        if (to_skid) begin
          skid_instr <= imem_rdata;
          skid_pc    <= pc;
        end
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
        if (branch_taken) begin
          redir_pend   <= 1'b1;
          redir_target <= branch_target;
        end
      end
    end
  end

  // IF/ID stage: flush/timeout beat loads, loads beat hold, else bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (flush || timeout_hit) begin
      if_valid <= 1'b0;
    end else if (load_fetch) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_instr <= imem_rdata;
    end else if (load_skid) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_instr <= skid_instr;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

  // Sticky fetch error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           fetch_error <= 1'b0;
    else if (timeout_hit) fetch_error <= 1'b1;
  end

endmodule
